// File: rtl/response_sm_pkg.sv
// Shared constants and types for the response packet transmitter.
// Holds the word widths, the stream byte-enable constant and the one-hot state encoding.
package response_sm_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int KEEP_W = DATA_W / 8;

    localparam logic [0:KEEP_W-1] TKEEP_ALL = 4'b1111;

    // One-hot bit positions; each state value sets exactly its own bit.
    localparam int ST_IDLE    = 0;
    localparam int ST_HDR_RSN = 1;
    localparam int ST_HDR_RC  = 2;
    localparam int ST_HDR_RDC = 3;
    localparam int ST_FETCH   = 4;
    localparam int ST_LOAD    = 5;
    localparam int ST_SEND_RD = 6;
    localparam int ST_DONE    = 7;
    localparam int NUM_STATES = 8;

    typedef enum logic [NUM_STATES-1:0] {
        IDLE    = NUM_STATES'(1 << ST_IDLE),
        HDR_RSN = NUM_STATES'(1 << ST_HDR_RSN),
        HDR_RC  = NUM_STATES'(1 << ST_HDR_RC),
        HDR_RDC = NUM_STATES'(1 << ST_HDR_RDC),
        FETCH   = NUM_STATES'(1 << ST_FETCH),
        LOAD    = NUM_STATES'(1 << ST_LOAD),
        SEND_RD = NUM_STATES'(1 << ST_SEND_RD),
        DONE    = NUM_STATES'(1 << ST_DONE)
    } state_t;

    function automatic logic [CNT_W-1:0] clamp_count(
        input logic [CNT_W-1:0] req,
        input logic [CNT_W-1:0] lim
    );
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/response_sm_if.sv
// Signal bundle between the response transmitter and its neighbours:
// command-side request, response data RAM read port, tx stream and status pulses.
interface response_sm_if;
    import response_sm_pkg::*;

    logic              send_rsp;
    logic [DATA_W-1:0] ser_num;
    logic [DATA_W-1:0] rsp_code;
    logic [CNT_W-1:0]  rsp_count;

    logic              rd_en;
    logic [CNT_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic [DATA_W-1:0] tx_tdata;
    logic              tx_tvalid;
    logic [0:KEEP_W-1] tx_tkeep;
    logic              tx_tlast;
    logic              tx_tready;

    logic              rsp_busy;
    logic              rsp_done;
    logic              rsp_err;

    // Transmitter view
    modport master (
        input  send_rsp, ser_num, rsp_code, rsp_count, rd_data, tx_tready,
        output rd_en, rd_addr, tx_tdata, tx_tvalid, tx_tkeep, tx_tlast,
               rsp_busy, rsp_done, rsp_err
    );

    // Surrounding logic view (command side, RAM, tx FIFO)
    modport slave (
        output send_rsp, ser_num, rsp_code, rsp_count, rd_data, tx_tready,
        input  rd_en, rd_addr, tx_tdata, tx_tvalid, tx_tkeep, tx_tlast,
               rsp_busy, rsp_done, rsp_err
    );

endinterface

// File: rtl/response_sm.sv
// Emits one response packet (RSN, RC, RDC, RD1..RDn) as a 32-bit stream frame per send_rsp,
// fetching data words from an external response RAM with a one-cycle registered read.
module response_sm
    import response_sm_pkg::*;
#(
    parameter int MAX_WORDS = 255
) (
    input  logic          clk,
    input  logic          reset,
    response_sm_if.master bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] rc_reg, rc_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CNT_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-1:0] tdata_reg, tdata_next;
    logic              tvalid_reg, tvalid_next;
    logic              tlast_reg, tlast_next;
    logic              rd_en_reg, rd_en_next;
    logic [CNT_W-1:0]  rd_addr_reg, rd_addr_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc_reg      <= '0;
            count_reg   <= '0;
            idx_reg     <= '0;
            tdata_reg   <= '0;
            tvalid_reg  <= 1'b0;
            tlast_reg   <= 1'b0;
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            rc_reg      <= rc_next;
            count_reg   <= count_next;
            idx_reg     <= idx_next;
            tdata_reg   <= tdata_next;
            tvalid_reg  <= tvalid_next;
            tlast_reg   <= tlast_next;
            rd_en_reg   <= rd_en_next;
            rd_addr_reg <= rd_addr_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rc_next      = rc_reg;
        count_next   = count_reg;
        idx_next     = idx_reg;
        tdata_next   = tdata_reg;
        tvalid_next  = tvalid_reg;
        tlast_next   = tlast_reg;
        rd_en_next   = 1'b0;
        rd_addr_next = rd_addr_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.send_rsp) begin
                    rc_next     = bus.rsp_code;
                    count_next  = clamp_count(bus.rsp_count, MAX_CNT);
                    err_next    = (bus.rsp_count > MAX_CNT);
                    idx_next    = '0;
                    tdata_next  = bus.ser_num;
                    tvalid_next = 1'b1;
                    tlast_next  = 1'b0;
                    busy_next   = 1'b1;
                    state_next  = HDR_RSN;
                end
            end

            HDR_RSN: begin
                if (bus.tx_tready) begin
                    tdata_next = rc_reg;
                    state_next = HDR_RC;
                end
            end

            HDR_RC: begin
                if (bus.tx_tready) begin
                    tdata_next = {{(DATA_W-CNT_W){1'b0}}, count_reg};
                    tlast_next = (count_reg == '0);
                    state_next = HDR_RDC;
                end
            end

            HDR_RDC: begin
                if (bus.tx_tready) begin
                    tvalid_next = 1'b0;
                    tlast_next  = 1'b0;
                    if (count_reg == '0) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        rd_en_next   = 1'b1;
                        rd_addr_next = idx_reg;
                        state_next   = FETCH;
                    end
                end
            end

            // RAM is sampling rd_addr this cycle; its data appears during LOAD.
            FETCH: begin
                state_next = LOAD;
            end

            LOAD: begin
                tdata_next  = bus.rd_data;
                tvalid_next = 1'b1;
                tlast_next  = (idx_reg == count_reg - CNT_W'(1));
                state_next  = SEND_RD;
            end

            SEND_RD: begin
                if (bus.tx_tready) begin
                    tvalid_next = 1'b0;
                    tlast_next  = 1'b0;
                    idx_next    = idx_reg + CNT_W'(1);
                    if (tlast_reg) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        rd_en_next   = 1'b1;
                        rd_addr_next = idx_reg + CNT_W'(1);
                        state_next   = FETCH;
                    end
                end
            end

            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                tvalid_next = 1'b0;
                tlast_next  = 1'b0;
                busy_next   = 1'b0;
                state_next  = IDLE;
            end
        endcase

        // A request arriving anywhere but IDLE (including DONE) is dropped and flagged.
        if (bus.send_rsp && (state_reg != IDLE)) begin
            err_next = 1'b1;
        end
    end

    assign bus.tx_tdata  = tdata_reg;
    assign bus.tx_tvalid = tvalid_reg;
    assign bus.tx_tlast  = tlast_reg;
    assign bus.rd_en     = rd_en_reg;
    assign bus.rd_addr   = rd_addr_reg;
    assign bus.rsp_busy  = busy_reg;
    assign bus.rsp_done  = done_reg;
    assign bus.rsp_err   = err_reg;

    for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_keep
        assign bus.tx_tkeep[gi] = tvalid_reg & TKEEP_ALL[gi];
    end

endmodule
